memory_bus_arbiter: RTL and testbench
=====================================

# memory_bus_arbiter

Two-requester arbiter that shares the single memory bus between the RISC-V core (port 0) and a debug/DMA master (port 1). It registers one transaction at a time onto the memory side, returns read data and a one-cycle `ready` to the winning requester, and breaks ties round-robin. A watchdog terminates transactions the memory never acknowledges and latches a sticky bus error for the debug hardware.

## Interface
Parameters:
- `ADDRESS_SIZE`, 15: width of word address on all ports.
- `TIMEOUT_CYCLES`, 255: cycles in BUSY without `mem_ready` before forced completion; legal range 2..65535.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_strobe`, `m1_strobe`  in  1  request valid; held high until the matching `mX_ready`.
- `m0_address`, `m1_address`  in  ADDRESS_SIZE  word address.
- `m0_writeEnable`, `m1_writeEnable`  in  4  byte write mask; 0 = read.
- `m0_dataWrite`, `m1_dataWrite`  in  32  write data.
- `m0_dataRead`, `m1_dataRead`  out  32  read data, valid while `mX_ready` = 1.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `mem_strobe`  out  1  transaction active toward memory.
- `mem_address`  out  ADDRESS_SIZE; `mem_writeEnable`  out  4; `mem_dataWrite`  out  32.
- `mem_dataRead`  in  32; `mem_ready`  in  1  memory completion.
- `clearError`  in  1  synchronous clear of the sticky error.
- `busError`  out  1  sticky timeout flag; `errorOwner`  out  1  requester of the last timed-out transaction.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: sample strobes. If neither is high, stay. If one is high, grant it. If both are high, grant the one that is not `lastOwner`. On grant, register `owner`, address, mask and data into `mem_*`, set `mem_strobe` = 1, clear the watchdog, and go to BUSY.
- BUSY: `mem_*` outputs stay stable. Requester inputs are ignored, so a requester changing its inputs mid-transaction is a protocol violation with no effect.
  - `mem_ready` = 1: latch `mem_dataRead` into `rdata`, drop `mem_strobe`, go to DONE.
  - Otherwise, if the watchdog reaches TIMEOUT_CYCLES−1: set `rdata` = 0, `busError` = 1, `errorOwner` = `owner`, drop `mem_strobe`, go to DONE.
- DONE (exactly one cycle): `m[owner]_ready` = 1 and `m[owner]_dataRead` = `rdata`. Set `lastOwner` = `owner`, then go to IDLE. Strobes are ignored in DONE.
- The non-owner's `mX_ready` is always 0. `mX_dataRead` outputs the latched `rdata` on both ports; only the one with `ready` set is meaningful.
- Watchdog: 16-bit counter, increments each BUSY cycle, saturates. `mem_ready` in the same cycle as the timeout threshold counts as a normal completion (ready wins).
- `clearError` = 1 clears `busError` on the next edge. If a timeout sets `busError` in the same cycle, the set wins.
- Write transactions (`writeEnable` ≠ 0) follow the identical sequence; `rdata` still latches `mem_dataRead` and is don't-care to the requester.
- Reset (async, any state): state = IDLE, `owner` = 0, `lastOwner` = 1 (core wins the first tie), `mem_strobe` = 0, `mem_address` = 0, `mem_writeEnable` = 0, `mem_dataWrite` = 0, `rdata` = 0, `m0_ready` = `m1_ready` = 0, `busError` = 0, `errorOwner` = 0, watchdog = 0. An aborted transaction is not completed to its requester.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Strobe sampled high in IDLE at edge E0 → `mem_strobe` high during E0..E1.
- `mem_ready` sampled at edge Ek → `mX_ready` high for exactly the cycle Ek..Ek+1 → IDLE from Ek+1.
- Minimum latency: request seen at E0, memory ready at E1, requester ready in cycle E1..E2. That is 2 cycles strobe-to-ready, and 3 cycles between back-to-back grants.
- Requester contract: drop `strobe` at the edge ending its ready cycle, unless it issues a new request. A strobe still high in IDLE is a new transaction.
- `mem_strobe` is low for at least 2 cycles (DONE plus IDLE sample) between transactions.
- Timeout: with no `mem_ready`, `mem_strobe` stays high for exactly TIMEOUT_CYCLES cycles.

## Test plan
- Single read, m0, address 0x0010, memory returns 0xDEADBEEF one cycle after `mem_strobe` → `m0_ready` pulses once, 2 cycles after strobe sampled, with `m0_dataRead` = 0xDEADBEEF; `m1_ready` stays 0.
- Both strobes high out of reset, continuously, 3 transactions each → grant order m0, m1, m0, m1, m0, m1; `mem_address` matches each owner's address.
- m1 write with mask 4'b0011, data 0x12345678, memory holds `mem_ready` low for 5 cycles → `mem_*` stable for all 6 BUSY cycles, then one `m1_ready` pulse.
- Memory never readies, TIMEOUT_CYCLES = 8 → `mem_strobe` high for 8 cycles, `m0_ready` pulses with data 0, `busError` = 1, `errorOwner` = 0. Then `clearError` → `busError` = 0. Also check a timeout and `clearError` in the same cycle → `busError` = 1.
- `reset` asserted mid-BUSY, between edges → all outputs at reset values immediately. After release, the m0/m1 tie goes to m0 and no stale ready is seen.
- `mem_ready` arriving exactly on the timeout cycle → normal data returned, `busError` stays 0.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares one memory bus between the core (m0) and a
// debug/DMA master (m1), one registered transaction at a time.
//
// Ports:
//   clock, reset            clock and async active-low reset
//   mX_strobe/address/      requester X request (held until mX_ready)
//   writeEnable/dataWrite
//   mX_dataRead, mX_ready   returned data and one-cycle completion pulse
//   mem_*                   registered memory-side transaction
//   clearError              synchronous clear of busError
//   busError, errorOwner    sticky watchdog timeout flag and its requester
module memory_bus_arbiter #(
    parameter int ADDRESS_SIZE   = 15,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    m0_strobe,
    input  logic [ADDRESS_SIZE-1:0] m0_address,
    input  logic [3:0]              m0_writeEnable,
    input  logic [31:0]             m0_dataWrite,
    output logic [31:0]             m0_dataRead,
    output logic                    m0_ready,
    input  logic                    m1_strobe,
    input  logic [ADDRESS_SIZE-1:0] m1_address,
    input  logic [3:0]              m1_writeEnable,
    input  logic [31:0]             m1_dataWrite,
    output logic [31:0]             m1_dataRead,
    output logic                    m1_ready,
    output logic                    mem_strobe,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [3:0]              mem_writeEnable,
    output logic [31:0]             mem_dataWrite,
    input  logic [31:0]             mem_dataRead,
    input  logic                    mem_ready,
    input  logic                    clearError,
    output logic                    busError,
    output logic                    errorOwner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    logic                    owner_q;
    logic                    last_owner_q;
    logic [15:0]             wd_q;
    logic [31:0]             rdata_q;
    logic [1:0]              ready_q;
    logic                    mem_strobe_q;
    logic [ADDRESS_SIZE-1:0] mem_address_q;
    logic [3:0]              mem_we_q;
    logic [31:0]             mem_wdata_q;
    logic                    bus_error_q;
    logic                    error_owner_q;
    logic                    grant_d;

    // Tie goes to whoever did not own the previous transaction.
    always_comb begin
        grant_d = m1_strobe & (~m0_strobe | ~last_owner_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            wd_q          <= '0;
            rdata_q       <= '0;
            ready_q       <= '0;
            mem_strobe_q  <= 1'b0;
            mem_address_q <= '0;
            mem_we_q      <= '0;
            mem_wdata_q   <= '0;
            bus_error_q   <= 1'b0;
            error_owner_q <= 1'b0;
        end else begin
            // A timeout set below overrides this clear.
            if (clearError) begin
                bus_error_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (m0_strobe | m1_strobe) begin
                        owner_q       <= grant_d;
                        mem_address_q <= grant_d ? m1_address : m0_address;
                        mem_we_q      <= grant_d ? m1_writeEnable
                                                 : m0_writeEnable;
                        mem_wdata_q   <= grant_d ? m1_dataWrite
                                                 : m0_dataWrite;
                        mem_strobe_q  <= 1'b1;
                        wd_q          <= '0;
                        state_q       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        rdata_q      <= mem_dataRead;
                        mem_strobe_q <= 1'b0;
                        ready_q      <= owner_q ? 2'b10 : 2'b01;
                        state_q      <= DONE;
                    end else if (wd_q == WD_LIMIT) begin
                        rdata_q       <= '0;
                        bus_error_q   <= 1'b1;
                        error_owner_q <= owner_q;
                        mem_strobe_q  <= 1'b0;
                        ready_q       <= owner_q ? 2'b10 : 2'b01;
                        state_q       <= DONE;
                    end else if (wd_q != 16'hFFFF) begin
                        wd_q <= wd_q + 16'd1;
                    end
                end
                DONE: begin
                    ready_q      <= '0;
                    last_owner_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m0_ready        = ready_q[0];
    assign m1_ready        = ready_q[1];
    assign m0_dataRead     = rdata_q;
    assign m1_dataRead     = rdata_q;
    assign mem_strobe      = mem_strobe_q;
    assign mem_address     = mem_address_q;
    assign mem_writeEnable = mem_we_q;
    assign mem_dataWrite   = mem_wdata_q;
    assign busError        = bus_error_q;
    assign errorOwner      = error_owner_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed and randomized transactions against a
// transaction-level model of arbitration, latency, timeout and error flag.
module tb_memory_bus_arbiter;

    localparam int AW = 15;
    localparam int T  = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          m0_strobe = 0, m1_strobe = 0;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic [3:0]    m0_writeEnable = '0, m1_writeEnable = '0;
    logic [31:0]   m0_dataWrite = '0, m1_dataWrite = '0;
    logic [31:0]   m0_dataRead, m1_dataRead;
    logic          m0_ready, m1_ready;
    logic          mem_strobe;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_writeEnable;
    logic [31:0]   mem_dataWrite;
    logic [31:0]   mem_dataRead = '0;
    logic          mem_ready = 1'b0;
    logic          clearError = 1'b0;
    logic          busError, errorOwner;

    int checks = 0;
    int errors = 0;

    // Reference state: who owned the last completed transaction,
    // and the sticky error flag with its owner.
    bit last_m = 1'b1;
    bit err_m  = 1'b0;
    bit eown_m = 1'b0;

    memory_bus_arbiter #(
        .ADDRESS_SIZE  (AW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .m0_strobe      (m0_strobe),
        .m0_address     (m0_address),
        .m0_writeEnable (m0_writeEnable),
        .m0_dataWrite   (m0_dataWrite),
        .m0_dataRead    (m0_dataRead),
        .m0_ready       (m0_ready),
        .m1_strobe      (m1_strobe),
        .m1_address     (m1_address),
        .m1_writeEnable (m1_writeEnable),
        .m1_dataWrite   (m1_dataWrite),
        .m1_dataRead    (m1_dataRead),
        .m1_ready       (m1_ready),
        .mem_strobe     (mem_strobe),
        .mem_address    (mem_address),
        .mem_writeEnable(mem_writeEnable),
        .mem_dataWrite  (mem_dataWrite),
        .mem_dataRead   (mem_dataRead),
        .mem_ready      (mem_ready),
        .clearError     (clearError),
        .busError       (busError),
        .errorOwner     (errorOwner)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " mem_strobe"}, 64'(mem_strobe), 0);
        chk({tag, " mem_address"}, 64'(mem_address), 0);
        chk({tag, " mem_we"}, 64'(mem_writeEnable), 0);
        chk({tag, " mem_wdata"}, 64'(mem_dataWrite), 0);
        chk({tag, " readys"}, 64'({m1_ready, m0_ready}), 0);
        chk({tag, " dataRead"}, 64'({m1_dataRead, m0_dataRead}), 0);
        chk({tag, " busError"}, 64'(busError), 0);
        chk({tag, " errorOwner"}, 64'(errorOwner), 0);
    endtask

    // One full transaction. Called just after an edge with the DUT idle.
    // delay = BUSY cycles memory keeps mem_ready low before completing.
    task automatic txn(input bit s0, input bit s1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [3:0] w0, input logic [3:0] w1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input int delay, input logic [31:0] mdata,
                       input bit clr);
        bit            own;
        bit            tmo;
        int            k;
        logic [AW-1:0] ea;
        logic [3:0]    ew;
        logic [31:0]   ed;
        logic [31:0]   erd;
        @(negedge clock);
        m0_strobe = s0; m1_strobe = s1;
        m0_address = a0; m1_address = a1;
        m0_writeEnable = w0; m1_writeEnable = w1;
        m0_dataWrite = d0; m1_dataWrite = d1;
        clearError = clr;
        mem_ready = 1'b0;
        own = (s0 && s1) ? !last_m : s1;
        ea = own ? a1 : a0;
        ew = own ? w1 : w0;
        ed = own ? d1 : d0;
        tmo = (delay + 1) > T;
        k = tmo ? T : delay + 1;
        erd = tmo ? 32'd0 : mdata;
        tick();
        chk("grant mem_strobe", 64'(mem_strobe), 1);
        chk("grant mem_address", 64'(mem_address), 64'(ea));
        chk("grant mem_we", 64'(mem_writeEnable), 64'(ew));
        chk("grant mem_wdata", 64'(mem_dataWrite), 64'(ed));
        for (int i = 1; i <= k; i++) begin
            @(negedge clock);
            // Requester inputs wiggle mid-transaction; must be ignored.
            m0_address = AW'($urandom);
            m1_address = AW'($urandom);
            m0_dataWrite = $urandom;
            m1_dataWrite = $urandom;
            if (i == delay + 1) begin
                mem_ready = 1'b1;
                mem_dataRead = mdata;
            end else begin
                mem_dataRead = $urandom;
            end
            tick();
            if (i < k) begin
                chk("busy mem_strobe", 64'(mem_strobe), 1);
                chk("busy mem_stable",
                    64'({mem_address, mem_writeEnable, mem_dataWrite}),
                    64'({ea, ew, ed}));
                chk("busy readys", 64'({m1_ready, m0_ready}), 0);
            end
        end
        if (tmo) begin
            err_m = 1'b1;
            eown_m = own;
        end else if (clr) begin
            err_m = 1'b0;
        end
        chk("done mem_strobe", 64'(mem_strobe), 0);
        chk("done readys", 64'({m1_ready, m0_ready}),
            own ? 64'd2 : 64'd1);
        chk("done m0_dataRead", 64'(m0_dataRead), 64'(erd));
        chk("done m1_dataRead", 64'(m1_dataRead), 64'(erd));
        chk("done busError", 64'(busError), 64'(err_m));
        chk("done errorOwner", 64'(errorOwner), 64'(eown_m));
        last_m = own;
        @(negedge clock);
        mem_ready = 1'b0;
        m0_strobe = 1'b0;
        m1_strobe = 1'b0;
        clearError = 1'b0;
        tick();
        chk("after readys", 64'({m1_ready, m0_ready}), 0);
        chk("after mem_strobe", 64'(mem_strobe), 0);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clearError = 1'b1;
        tick();
        err_m = 1'b0;
        chk("clearError busError", 64'(busError), 64'(err_m));
        @(negedge clock);
        clearError = 1'b0;
    endtask

    initial begin
        #1;
        chk_reset_values("por");
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Tie out of reset: m0 first, then alternating.
        for (int n = 0; n < 6; n++) begin
            txn(1, 1, AW'(16'h100 + n), AW'(16'h200 + n), 4'h0, 4'h0,
                $urandom, $urandom, $urandom_range(0, 3), $urandom, 0);
            chk("tie order", 64'(last_m), 64'(n % 2));
        end

        txn(1, 0, AW'(16'h0010), '0, 4'h0, 4'h0, '0, '0,
            0, 32'hDEADBEEF, 0);

        txn(0, 1, '0, AW'(16'h0ABC), 4'h0, 4'b0011, '0, 32'h12345678,
            5, $urandom, 0);

        // Memory never responds.
        txn(1, 0, AW'(16'h0040), '0, 4'h0, 4'h0, '0, '0,
            100, $urandom, 0);
        pulse_clear();

        // Timeout with clearError held: set wins.
        txn(0, 1, '0, AW'(16'h0050), 4'hF, 4'hF, '0, 32'hCAFEF00D,
            100, $urandom, 1);
        pulse_clear();

        // mem_ready on the timeout cycle: normal completion.
        txn(1, 0, AW'(16'h0060), '0, 4'h0, 4'h0, '0, '0,
            T - 1, 32'hA5A5_5A5A, 0);
        chk("ready-wins busError", 64'(busError), 0);

        // Set the error again, then reset mid-BUSY.
        txn(1, 0, AW'(16'h0070), '0, 4'h0, 4'h0, '0, '0,
            100, $urandom, 0);
        txn(0, 1, '0, AW'(16'h0071), 4'h0, 4'h3, '0, 32'h77, 0,
            32'h11, 0);
        @(negedge clock);
        m0_strobe = 1'b1;
        m0_address = AW'(16'h0123);
        m0_writeEnable = 4'hF;
        m0_dataWrite = 32'h5555AAAA;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk_reset_values("midbusy");
        last_m = 1'b1;
        err_m = 1'b0;
        eown_m = 1'b0;
        @(negedge clock);
        m0_strobe = 1'b0;
        reset = 1'b1;
        tick();
        chk("post-reset readys", 64'({m1_ready, m0_ready}), 0);
        txn(1, 1, AW'(16'h0301), AW'(16'h0302), 4'h0, 4'h0, '0, '0,
            1, $urandom, 0);
        chk("post-reset tie", 64'(last_m), 0);

        for (int n = 0; n < 40; n++) begin
            int s;
            s = $urandom_range(1, 3);
            txn(s[0], s[1], AW'($urandom), AW'($urandom),
                4'($urandom), 4'($urandom), $urandom, $urandom,
                $urandom_range(0, 10), $urandom, ($urandom % 8) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
